// File: rtl/pulse_tx_pkg.sv
// Shared types and default sizing for the pulse train transmitter.
package pulse_tx_pkg;

    localparam int unsigned DEFAULT_CNT_W      = 16;
    localparam int unsigned DEFAULT_MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } pulse_tx_state_t;

endpackage : pulse_tx_pkg

// File: rtl/phase_timer.sv
// Phase duration down-counter: loaded with a cycle count, expire_out is high
// during the last cycle of that count.
// Ports:
//   clk_in, rst_in - clock, async active-high reset
//   load_in        - load count_in (count must be >= 1)
//   count_in       - number of cycles in the phase being started
//   expire_out     - registered, high on the final cycle of the phase
module phase_timer
    import pulse_tx_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] count_in,
    output logic             expire_out
);

    logic [CNT_W-1:0] remain_q;

    // Expire is precomputed one cycle ahead so it lines up with remain_q==1.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            remain_q   <= '0;
            expire_out <= 1'b0;
        end else if (load_in) begin
            remain_q   <= count_in;
            expire_out <= (count_in == CNT_W'(1));
        end else if (remain_q != '0) begin
            remain_q   <= remain_q - CNT_W'(1);
            expire_out <= (remain_q == CNT_W'(2));
        end
    end

endmodule : phase_timer

// File: rtl/pulse_train_tx.sv
// Pulse train transmitter: emits N rectangular pulses of period P and high
// time H on pulse_out, with a start/busy/done handshake and a sent counter.
// Optional macro PULSE_TX_ABORT_EN adds abort_in to cut a burst short.
// Ports:
//   clk_in, rst_in   - clock, async active-high reset
//   start_in         - launch request, honoured only in IDLE/DONE
//   num_pulses_in    - N, pulses per burst (0 gives an immediate done)
//   period_in        - P, cycles per pulse, raised to MIN_PERIOD
//   high_cycles_in   - H, high cycles per pulse, clamped to [1, P_eff-1]
//   abort_in         - (PULSE_TX_ABORT_EN only) end the burst on next edge
//   pulse_out        - registered pulse line
//   busy_out         - burst in progress
//   done_out         - one-cycle strobe after the burst
//   sent_count_out   - pulses started in the current/last burst
module pulse_train_tx
    import pulse_tx_pkg::*;
#(
    parameter int unsigned CNT_W      = DEFAULT_CNT_W,
    parameter int unsigned MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [CNT_W-1:0] num_pulses_in,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_cycles_in,
`ifdef PULSE_TX_ABORT_EN
    input  logic             abort_in,
`endif
    output logic             pulse_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [CNT_W-1:0] sent_count_out
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    pulse_tx_state_t  state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W-1:0] sent_d;
    logic             pulse_d, busy_d, done_d;

    logic [CNT_W-1:0] p_eff_c, h_eff_c;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_count_c;
    logic             tmr_expire;

    // Effective period/high time from the live inputs; only used at start.
    always_comb begin
        p_eff_c = (period_in < MIN_P) ? MIN_P : period_in;
        if (high_cycles_in == '0) begin
            h_eff_c = CNT_W'(1);
        end else if (high_cycles_in >= p_eff_c) begin
            h_eff_c = p_eff_c - CNT_W'(1);
        end else begin
            h_eff_c = high_cycles_in;
        end
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_in    (tmr_load_c),
        .count_in   (tmr_count_c),
        .expire_out (tmr_expire)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        high_d      = high_q;
        low_d       = low_q;
        sent_d      = sent_count_out;
        pulse_d     = pulse_out;
        busy_d      = busy_out;
        done_d      = 1'b0;
        tmr_load_c  = 1'b0;
        tmr_count_c = high_q;

        case (state_q)
            IDLE, DONE: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                if (start_in) begin
                    num_d  = num_pulses_in;
                    high_d = h_eff_c;
                    low_d  = p_eff_c - h_eff_c;
                    sent_d = '0;
                    if (num_pulses_in == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = HIGH;
                        pulse_d     = 1'b1;
                        busy_d      = 1'b1;
                        sent_d      = CNT_W'(1);
                        tmr_load_c  = 1'b1;
                        tmr_count_c = h_eff_c;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    state_d     = LOW;
                    pulse_d     = 1'b0;
                    tmr_load_c  = 1'b1;
                    tmr_count_c = low_q;
                end
            end
            LOW: begin
                if (tmr_expire) begin
                    if (sent_count_out == num_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = HIGH;
                        pulse_d     = 1'b1;
                        sent_d      = sent_count_out + CNT_W'(1);
                        tmr_load_c  = 1'b1;
                        tmr_count_c = high_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

`ifdef PULSE_TX_ABORT_EN
        // Abort overrides any phase transition computed above.
        if (abort_in && (state_q == HIGH || state_q == LOW)) begin
            state_d    = DONE;
            pulse_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            sent_d     = sent_count_out;
            tmr_load_c = 1'b0;
        end
`endif
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            num_q          <= '0;
            high_q         <= '0;
            low_q          <= '0;
            sent_count_out <= '0;
            pulse_out      <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            high_q         <= high_d;
            low_q          <= low_d;
            sent_count_out <= sent_d;
            pulse_out      <= pulse_d;
            busy_out       <= busy_d;
            done_out       <= done_d;
        end
    end

endmodule : pulse_train_tx

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx: captures pulse/busy/done per cycle after
// each launch and compares against hand-written waveforms (MSB = first cycle).
module tb_pulse_train_tx;

    localparam int unsigned CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             start_in = 1'b0;
    logic [CNT_W-1:0] num_pulses_in = '0;
    logic [CNT_W-1:0] period_in = '0;
    logic [CNT_W-1:0] high_cycles_in = '0;
`ifdef PULSE_TX_ABORT_EN
    logic             abort_in = 1'b0;
`endif
    logic             pulse_out;
    logic             busy_out;
    logic             done_out;
    logic [CNT_W-1:0] sent_count_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    pulse_train_tx #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .num_pulses_in  (num_pulses_in),
        .period_in      (period_in),
        .high_cycles_in (high_cycles_in),
`ifdef PULSE_TX_ABORT_EN
        .abort_in       (abort_in),
`endif
        .pulse_out      (pulse_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .sent_count_out (sent_count_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a start request for the next rising edge.
    task automatic launch(input int n, input int p, input int h);
        num_pulses_in  = CNT_W'(n);
        period_in      = CNT_W'(p);
        high_cycles_in = CNT_W'(h);
        start_in       = 1'b1;
    endtask

    // Sample outputs on each falling edge; optionally poke an input
    // (kind 1 = re-start with other config, kind 2 = abort) after sample poke_at.
    task automatic capture(input int cycles, input int poke_at, input int kind,
                           output logic [63:0] pv, output logic [63:0] bv,
                           output logic [63:0] dv);
        pv = '0;
        bv = '0;
        dv = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            pv = {pv[62:0], pulse_out};
            bv = {bv[62:0], busy_out};
            dv = {dv[62:0], done_out};
            start_in = 1'b0;
`ifdef PULSE_TX_ABORT_EN
            abort_in = 1'b0;
`endif
            if (i == poke_at) begin
                if (kind == 1) begin
                    launch(5, 2, 1);
                end
`ifdef PULSE_TX_ABORT_EN
                if (kind == 2) begin
                    abort_in = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic run_check(input string tag, input int cycles, input int poke_at,
                             input int kind, input logic [63:0] ep,
                             input logic [63:0] eb, input logic [63:0] ed,
                             input int es);
        logic [63:0] pv, bv, dv;
        capture(cycles, poke_at, kind, pv, bv, dv);
        check({tag, ".pulse"}, pv, ep);
        check({tag, ".busy"},  bv, eb);
        check({tag, ".done"},  dv, ed);
        check({tag, ".sent"},  64'(sent_count_out), 64'(es));
    endtask

    initial begin
        logic [63:0] pv, bv, dv;

        // Reset state while rst_in is held.
        #1;
        check("in_reset", 64'({pulse_out, busy_out, done_out, sent_count_out}), 64'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_check("idle", 10, -1, 0, 64'd0, 64'd0, 64'd0, 0);

        // N=3 P=4 H=1: pulses at t+1,t+5,t+9, busy t+1..t+12, done t+13.
        launch(3, 4, 1);
        run_check("n3p4h1", 14, -1, 0, 64'b10001000100000, 64'b11111111111100,
                  64'b00000000000010, 3);

        // P below minimum and H=0: P_eff=2, H_eff=1.
        launch(2, 1, 0);
        run_check("clamp_p", 5, -1, 0, 64'b10100, 64'b11110, 64'b00001, 2);

        // H above P-1: H_eff=4, ends on the done cycle.
        launch(1, 5, 9);
        run_check("clamp_h", 6, -1, 0, 64'b111100, 64'b111110, 64'b000001, 1);

        // Start during the done strobe: next burst starts immediately.
        launch(2, 3, 1);
        run_check("b2b", 7, -1, 0, 64'b1001000, 64'b1111110, 64'b0000001, 2);
        run_check("to_idle", 1, -1, 0, 64'd0, 64'd0, 64'd0, 2);

        // N=0: done at t+1, no busy, no pulse, count cleared.
        launch(0, 4, 2);
        run_check("n0", 3, -1, 0, 64'b000, 64'b000, 64'b100, 0);

        // Re-start with other config mid-burst is ignored.
        launch(2, 4, 2);
        run_check("restart_ign", 9, 2, 1, 64'b110011000, 64'b111111110,
                  64'b000000001, 2);
        run_check("restart_idle", 3, -1, 0, 64'd0, 64'd0, 64'd0, 2);

        // Async reset in the first HIGH cycle.
        launch(3, 4, 2);
        capture(1, -1, 0, pv, bv, dv);
        check("pre_rst.pulse", pv, 64'd1);
        check("pre_rst.sent", 64'(sent_count_out), 64'd1);
        #1 rst_in = 1'b1;
        #1;
        check("async_rst", 64'({pulse_out, busy_out, done_out, sent_count_out}), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_check("post_rst", 4, -1, 0, 64'd0, 64'd0, 64'd0, 0);

`ifdef PULSE_TX_ABORT_EN
        // Abort in third pulse's LOW (cycle t+11): done at t+12, count 3.
        launch(10, 4, 2);
        run_check("abort", 12, 10, 2, 64'b110011001100, 64'b111111111110,
                  64'b000000000001, 3);
        run_check("abort_after", 2, -1, 0, 64'd0, 64'd0, 64'd0, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pulse_train_tx
